// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file with busy scoreboard.
package regfile_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ADDR_WIDTH = 5;

  // Index of the optional hard-wired zero register.
  localparam int ZERO_IDX = 0;

  // Low bit of port 'port' inside a packed per-port bus of 'width'-bit fields.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Bundle of read, write and reserve signals between issue/writeback and the register file.
interface regfile_scoreboard_if
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_READ   = 2
);

  logic [NUM_READ-1:0]            ReadEn;
  logic [NUM_READ*ADDR_WIDTH-1:0] ReadReg;
  logic [NUM_READ*DATA_WIDTH-1:0] ReadData;
  logic [NUM_READ-1:0]            ReadBusy;
  logic                           RegWrite;
  logic [ADDR_WIDTH-1:0]          WriteReg;
  logic [DATA_WIDTH-1:0]          WriteData;
  logic                           Reserve;
  logic [ADDR_WIDTH-1:0]          ReserveReg;
  logic [2**ADDR_WIDTH-1:0]       BusyMask;

  // Pipeline side: issues reads, writes and reservations.
  modport master (
    output ReadEn, ReadReg, RegWrite, WriteReg, WriteData, Reserve, ReserveReg,
    input  ReadData, ReadBusy, BusyMask
  );

  // Register file side.
  modport slave (
    input  ReadEn, ReadReg, RegWrite, WriteReg, WriteData, Reserve, ReserveReg,
    output ReadData, ReadBusy, BusyMask
  );

endinterface

// File: rtl/regfile_read_port.sv
// One registered read port: address decode, write bypass, zero-register force.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ZERO_REG   = 1,
  localparam int DEPTH     = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] regs [DEPTH],
  input  logic [DEPTH-1:0]      busy_nxt,
  input  logic                  write_ok,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] rd_data_p1,
  output logic                  rd_busy_p1
);

  logic                  is_zero;
  logic                  hit;
  logic [DATA_WIDTH-1:0] data_p0;
  logic                  busy_p0;

  // Select the value this port loads at the next edge.
  always_comb begin
    is_zero = (ZERO_REG != 0) && (addr == ADDR_WIDTH'(ZERO_IDX));
    hit     = write_ok && (write_reg == addr);
    data_p0 = hit ? write_data : regs[addr];
    // Busy is the post-edge value so a same-edge reserve or write is seen.
    busy_p0 = busy_nxt[addr];
    if (is_zero) begin
      data_p0 = '0;
      busy_p0 = 1'b0;
    end
  end

  // ---- p0 -> p1: output registers, held while the port is idle ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_p1 <= '0;
      rd_busy_p1 <= 1'b0;
    end else if (en) begin
      rd_data_p1 <= data_p0;
      rd_busy_p1 <= busy_p0;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy scoreboard, N registered read ports, one write port.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1
) (
  input logic                 Clock,
  input logic                 Reset_n,
  regfile_scoreboard_if.slave bus
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_nxt;
  logic                  write_ok;
  logic                  reserve_ok;

  // Writes and reservations aimed at a hard-wired zero register are dropped.
  assign write_ok   = bus.RegWrite &&
                      !((ZERO_REG != 0) && (bus.WriteReg == ADDR_WIDTH'(ZERO_IDX)));
  assign reserve_ok = bus.Reserve &&
                      !((ZERO_REG != 0) && (bus.ReserveReg == ADDR_WIDTH'(ZERO_IDX)));

  // Next busy vector: writeback clears, reserve sets; reserve applied last so the new producer wins.
  always_comb begin
    busy_nxt = busy;
    if (write_ok)   busy_nxt[bus.WriteReg]   = 1'b0;
    if (reserve_ok) busy_nxt[bus.ReserveReg] = 1'b1;
  end

  // Register storage, cleared by reset.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int n = 0; n < DEPTH; n++) regs[n] <= '0;
    end else if (write_ok) begin
      regs[bus.WriteReg] <= bus.WriteData;
    end
  end

  // Busy scoreboard flops.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) busy <= '0;
    else          busy <= busy_nxt;
  end

  assign bus.BusyMask = busy;

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    regfile_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG)
    ) u_rd (
      .clk        (Clock),
      .rst_n      (Reset_n),
      .en         (bus.ReadEn[i]),
      .addr       (bus.ReadReg[slice_lo(i, ADDR_WIDTH) +: ADDR_WIDTH]),
      .regs       (regs),
      .busy_nxt   (busy_nxt),
      .write_ok   (write_ok),
      .write_reg  (bus.WriteReg),
      .write_data (bus.WriteData),
      .rd_data_p1 (bus.ReadData[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH]),
      .rd_busy_p1 (bus.ReadBusy[i])
    );
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised register file with a per-register busy scoreboard, for the next pipelined datapath. Multiple registered read ports, one write port, write-to-read bypass and an optional hard-wired zero register. Each register carries a busy bit: set by the issue stage when an instruction claims it as destination, cleared when that instruction writes back. Sits between decode/issue and writeback; hazard logic consumes the busy outputs.

## Interface
Parameters:
- DATA_WIDTH, 64, register width in bits
- ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH
- NUM_READ, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1, register 0 always reads 0 and is never busy

Ports:
- Clock  in  1  single clock, all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- ReadEn  in  NUM_READ  per-port read enable
- ReadReg  in  NUM_READ*ADDR_WIDTH  packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- ReadData  out  NUM_READ*DATA_WIDTH  packed registered read data
- ReadBusy  out  NUM_READ  registered busy bit of the addressed register
- RegWrite  in  1  write enable
- WriteReg  in  ADDR_WIDTH  write address
- WriteData  in  DATA_WIDTH  write data
- Reserve  in  1  set busy bit of ReserveReg
- ReserveReg  in  ADDR_WIDTH  register being claimed
- BusyMask  out  2**ADDR_WIDTH  current busy bits, bit n = register n

## Operation
- Reset (Reset_n low, immediate): all registers 0, all busy bits 0, ReadData 0, ReadBusy 0, BusyMask 0. Reset mid-operation discards pending writes and reservations; outputs stay 0 until first enabled read after release.
- Write: on edge with RegWrite=1, register[WriteReg] <= WriteData and busy[WriteReg] <= 0. Ignored entirely when ZERO_REG=1 and WriteReg=0.
- Reserve: on edge with Reserve=1, busy[ReserveReg] <= 1. Ignored for register 0 when ZERO_REG=1.
- Same edge, Reserve and RegWrite to same register: data written, busy ends 1 (new producer wins).
- Read port i, ReadEn[i]=1: next edge loads ReadData[i] with register[ReadReg[i]] and ReadBusy[i] with the post-edge busy bit of that register.
- Bypass: if RegWrite=1 and WriteReg equals ReadReg[i] (and is not a suppressed zero-register write) the same cycle, ReadData[i] gets WriteData, not the old contents.
- ReadEn[i]=0: ReadData[i] and ReadBusy[i] hold.
- ZERO_REG=1, ReadReg[i]=0: ReadData[i] <= 0, ReadBusy[i] <= 0 regardless of write/reserve.
- Ports are independent; all may address the same register.
- BusyMask is combinational from the busy flops (no input paths).

## Timing
- Read latency: 1 cycle (address sampled at edge k, data valid after edge k).
- Write visible to a read sampled on the same edge (bypass), so effective write-to-read latency 0.
- Reserve visible on BusyMask after the edge; on ReadBusy for reads sampled on that same edge.
- No back-pressure, no stalls; every input is sampled every cycle.

## Structure
- Shared package regfile_pkg: default DATA_WIDTH/ADDR_WIDTH, zero-register index constant, packed-slice helper function for port i.
- One sub-module: regfile_read_port (one per port, via generate): address decode, bypass mux, zero-register force, output registers.
- Storage array, busy vector and write/reserve logic live in the top.

## Test plan
- Reset: write 0xDEAD to r5, assert Reset_n low mid-cycle -> ReadData, ReadBusy, BusyMask drop to 0 immediately; read r5 after release -> 0.
- Basic write/read: write 0x1234 to r7, read r7 on port 0 next cycle -> ReadData[0]=0x1234 one cycle later; ReadEn low -> value holds.
- Bypass: RegWrite r3=0xAAAA and ReadReg port0=r3, port1=r3 same cycle -> both ports show 0xAAAA after that edge.
- Zero register: write 0xFFFF to r0, Reserve r0 -> read r0 gives 0, ReadBusy 0, BusyMask[0]=0; with ZERO_REG=0 same sequence reads 0xFFFF and busy 1.
- Scoreboard: Reserve r9 -> BusyMask[9]=1; write r9=0x55 -> BusyMask[9]=0; simultaneous Reserve+write r9 -> data 0x55 stored, BusyMask[9]=1.
- Parameters: DATA_WIDTH=32, ADDR_WIDTH=3, NUM_READ=4 -> all four ports read distinct registers r1..r4 with values 0x11..0x44 correctly in one cycle.
